// File: rtl/jtbubl_dwnld_if.sv
// rtl/jtbubl_dwnld_if.sv - ROM download byte stream and SDRAM/PROM programming bus
interface jtbubl_dwnld_if;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [ 7:0] ioctl_data;
  logic        ioctl_wr;
  logic        sdram_ack;
  logic [21:0] prog_addr;
  logic [ 7:0] prog_data;
  logic [ 1:0] prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic        busy;
  logic        overflow;
  logic        tokio;

  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    input  prog_addr, prog_data, prog_mask, prog_we, prom_we, busy, overflow, tokio
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    output prog_addr, prog_data, prog_mask, prog_we, prom_we, busy, overflow, tokio
  );
endinterface

// File: rtl/jtbubl_dwnld.sv
// rtl/jtbubl_dwnld.sv - buffers downloaded ROM bytes and writes them to SDRAM or PROM
module jtbubl_dwnld #(
  parameter logic [24:0] PROM_START = 25'hC_0000,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic          clk,
  input  logic          rstn,
  jtbubl_dwnld_if.slave bus
);
  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, SDWR, PROMWR} state_t;

  state_t      state;
  logic [32:0] mem [BUF_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push;
  logic [24:0] head_addr, prom_off;
  logic [ 7:0] head_data;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign empty     = wr_ptr == rd_ptr;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = (state == IDLE) && !empty;
  assign push      = bus.ioctl_wr && (!full || pop);
  assign head_addr = mem[rd_ptr[AW-1:0]][32:8];
  assign head_data = mem[rd_ptr[AW-1:0]][7:0];
  assign prom_off  = head_addr - PROM_START;
  assign bus.busy  = bus.downloading || !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (rstn && push) mem[wr_ptr[AW-1:0]] <= {bus.ioctl_addr, bus.ioctl_data};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.prog_we   <= 1'b0;
      bus.prom_we   <= 1'b0;
      bus.prog_addr <= '0;
      bus.prog_data <= '0;
      bus.prog_mask <= 2'b11;
      bus.overflow  <= 1'b0;
      bus.tokio     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.ioctl_wr && full && !pop) bus.overflow <= 1'b1;
      if (bus.ioctl_wr && bus.ioctl_addr == 25'd0) bus.tokio <= (bus.ioctl_data == 8'h7E);

      case (state)
        IDLE: begin
          if (pop) begin
            bus.prog_data <= head_data;
            if (head_addr < PROM_START) begin
              state         <= SDWR;
              bus.prog_addr <= head_addr[22:1];
              bus.prog_mask <= head_addr[0] ? 2'b01 : 2'b10;
              bus.prog_we   <= 1'b1;
            end else begin
              state         <= PROMWR;
              bus.prog_addr <= {14'd0, prom_off[7:0]};
              bus.prom_we   <= 1'b1;
            end
          end
        end
        SDWR: begin
          if (bus.sdram_ack) begin
            bus.prog_we <= 1'b0;
            state       <= IDLE;
          end
        end
        PROMWR: begin
          bus.prom_we <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtbubl_dwnld.sv
// tb/tb_jtbubl_dwnld.sv - directed vector bench for jtbubl_dwnld
module tb_jtbubl_dwnld;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;

  jtbubl_dwnld_if bus ();

  jtbubl_dwnld dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic [ 7:0] data;
    logic        prom;
    logic [21:0] exp_addr;
    logic [ 1:0] exp_mask;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [24:0] addr, input logic [7:0] data);
    bus.ioctl_addr = addr;
    bus.ioctl_data = data;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk);
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic wait_sd(input string name, input logic [21:0] exp_addr, input logic [7:0] exp_data);
    for (int i = 0; i < 30; i++) begin
      if (bus.prog_we) break;
      @(negedge clk);
    end
    check({name, "_we"}, bus.prog_we, 1);
    check({name, "_data"}, bus.prog_data, exp_data);
    check({name, "_addr"}, bus.prog_addr, exp_addr);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    check({name, "_we_low"}, bus.prog_we, 0);
  endtask

  initial begin
    logic seen;

    vecs[0] = '{25'h0_0005, 8'hA5, 1'b0, 22'h000002, 2'b01};
    vecs[1] = '{25'h0_1234, 8'h3C, 1'b0, 22'h00091A, 2'b10};
    vecs[2] = '{25'h0_BFFFF, 8'h5A, 1'b0, 22'h05FFFF, 2'b01};
    vecs[3] = '{25'h0_AAAA, 8'h77, 1'b0, 22'h005555, 2'b10};
    vecs[4] = '{25'h0_C0000, 8'h11, 1'b1, 22'h000000, 2'b00};
    vecs[5] = '{25'h0_C0013, 8'h0F, 1'b1, 22'h000013, 2'b00};
    vecs[6] = '{25'h0_C01FF, 8'h99, 1'b1, 22'h0000FF, 2'b00};

    rstn = 1'b0;
    bus.downloading = 1'b0;
    bus.ioctl_addr  = '0;
    bus.ioctl_data  = '0;
    bus.ioctl_wr    = 1'b0;
    bus.sdram_ack   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_prog_we", bus.prog_we, 0);
    check("rst_prom_we", bus.prom_we, 0);
    check("rst_prog_addr", bus.prog_addr, 0);
    check("rst_prog_data", bus.prog_data, 0);
    check("rst_prog_mask", bus.prog_mask, 2'b11);
    check("rst_overflow", bus.overflow, 0);
    check("rst_tokio", bus.tokio, 0);
    check("rst_busy", bus.busy, 0);

    rstn = 1'b1;
    bus.downloading = 1'b1;
    @(negedge clk);
    check("busy_downloading", bus.busy, 1);

    for (int v = 0; v < 7; v++) begin
      strobe(vecs[v].addr, vecs[v].data);
      check($sformatf("v%0d_we_early", v), {bus.prog_we, bus.prom_we}, 2'b00);
      @(negedge clk);
      if (!vecs[v].prom) begin
        check($sformatf("v%0d_prog_we", v), bus.prog_we, 1);
        check($sformatf("v%0d_addr", v), bus.prog_addr, vecs[v].exp_addr);
        check($sformatf("v%0d_mask", v), bus.prog_mask, vecs[v].exp_mask);
        check($sformatf("v%0d_data", v), bus.prog_data, vecs[v].data);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_hold", v),
              {bus.prog_we, bus.prog_addr, bus.prog_mask, bus.prog_data},
              {1'b1, vecs[v].exp_addr, vecs[v].exp_mask, vecs[v].data});
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        check($sformatf("v%0d_we_drop", v), bus.prog_we, 0);
      end else begin
        check($sformatf("v%0d_prom_we", v), {bus.prom_we, bus.prog_we}, 2'b10);
        check($sformatf("v%0d_addr", v), bus.prog_addr, vecs[v].exp_addr);
        check($sformatf("v%0d_data", v), bus.prog_data, vecs[v].data);
        @(negedge clk);
        check($sformatf("v%0d_prom_pulse", v), {bus.prom_we, bus.prog_we}, 2'b00);
      end
      @(negedge clk);
    end

    // First byte parks in SDWR, the next two fill the buffer, the last is lost.
    strobe(25'h100, 8'h01);
    @(negedge clk);
    strobe(25'h102, 8'h02);
    @(negedge clk);
    strobe(25'h104, 8'h03);
    @(negedge clk);
    check("ovf_not_yet", bus.overflow, 0);
    strobe(25'h106, 8'h04);
    @(negedge clk);
    check("ovf_set", bus.overflow, 1);
    repeat (12) @(negedge clk);
    check("ovf_hold", {bus.prog_we, bus.prog_data}, {1'b1, 8'h01});
    wait_sd("ovf_b1", 22'h80, 8'h01);
    wait_sd("ovf_b2", 22'h81, 8'h02);
    wait_sd("ovf_b3", 22'h82, 8'h03);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.prog_we) seen = 1'b1;
    end
    check("ovf_dropped", seen, 0);
    check("ovf_sticky", bus.overflow, 1);

    strobe(25'h0, 8'h7E);
    check("tokio_set", bus.tokio, 1);
    wait_sd("tok_w1", 22'h0, 8'h7E);
    strobe(25'h0, 8'h00);
    check("tokio_clr", bus.tokio, 0);
    wait_sd("tok_w2", 22'h0, 8'h00);
    strobe(25'h0, 8'h7E);
    wait_sd("tok_w3", 22'h0, 8'h7E);
    bus.downloading = 1'b0;
    repeat (4) @(negedge clk);
    check("tokio_hold", bus.tokio, 1);
    check("busy_idle", bus.busy, 0);

    // Reset while one write is in SDWR and one more is buffered.
    bus.downloading = 1'b1;
    strobe(25'h10, 8'hAA);
    strobe(25'h12, 8'hBB);
    check("pre_rst_we", bus.prog_we, 1);
    rstn = 1'b0;
    bus.downloading = 1'b0;
    @(negedge clk);
    check("mid_rst_we", bus.prog_we, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ovf", bus.overflow, 0);
    check("mid_rst_tokio", bus.tokio, 0);
    strobe(25'h0, 8'h7E);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.prog_we || bus.prom_we || bus.busy) seen = 1'b1;
    end
    check("post_rst_quiet", seen, 0);
    check("rst_ignored_tokio", bus.tokio, 0);

    // Download ends with two entries pending behind an active write.
    bus.downloading = 1'b1;
    strobe(25'h20, 8'hC1);
    strobe(25'h22, 8'hC2);
    strobe(25'h24, 8'hC3);
    bus.downloading = 1'b0;
    check("drain_busy", bus.busy, 1);
    wait_sd("drain_c1", 22'h10, 8'hC1);
    wait_sd("drain_c2", 22'h11, 8'hC2);
    wait_sd("drain_c3", 22'h12, 8'hC3);
    strobe(25'h27, 8'hD4);
    wait_sd("late_byte", 22'h13, 8'hD4);
    repeat (2) @(negedge clk);
    check("drain_done", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
